// File: rtl/switch_debounce.sv
// switch_debounce: per-bit 2-flop synchronizer, stable-count debouncer, clean level plus rise/fall pulses
module switch_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] s_db,
    output logic [WIDTH-1:0] s_rise,
    output logic [WIDTH-1:0] s_fall,
    output logic             any_change
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [WIDTH-1:0] s_db_q, s_db_d, s_rise_q, s_rise_d, s_fall_q, s_fall_d;
    logic             any_change_q, any_change_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // next state: a bit is accepted only after DEBOUNCE_CYCLES consecutive mismatching synced samples
    always_comb begin
        sync1_d  = s;
        sync2_d  = sync1_q;
        s_db_d   = s_db_q;
        s_rise_d = '0;
        s_fall_d = '0;
        cnt_d    = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == s_db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                s_db_d[i]   = sync2_q[i];
                s_rise_d[i] = sync2_q[i];
                s_fall_d[i] = ~sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        any_change_d = |(s_rise_d | s_fall_d);
    end

    // state registers; reset discards any count in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            s_db_q       <= '0;
            s_rise_q     <= '0;
            s_fall_q     <= '0;
            any_change_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            s_db_q       <= s_db_d;
            s_rise_q     <= s_rise_d;
            s_fall_q     <= s_fall_d;
            any_change_q <= any_change_d;
            cnt_q        <= cnt_d;
        end
    end

    assign s_db       = s_db_q;
    assign s_rise     = s_rise_q;
    assign s_fall     = s_fall_q;
    assign any_change = any_change_q;
endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: vector table, corner-case sequences and randomized run against a sliding-window model
module tb_switch_debounce;
    localparam int W = 4;
    localparam int D = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [W-1:0] s = '0;
    logic [W-1:0] s_db, s_rise, s_fall;
    logic any_change;
    logic [W-1:0] s_db2, s_rise2, s_fall2;
    logic any_change2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .s(s), .s_db(s_db), .s_rise(s_rise),
        .s_fall(s_fall), .any_change(any_change)
    );

    switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .s(s), .s_db(s_db2), .s_rise(s_rise2),
        .s_fall(s_fall2), .any_change(any_change2)
    );

    // reference model: input history since reset, and a window of the last D synchronized samples
    logic [W-1:0] shist[$];
    logic [W-1:0] win[$];
    logic [W-1:0] m_db = '0, m_rise = '0, m_fall = '0;
    logic m_any = 1'b0;

    task automatic model_step();
        logic [W-1:0] v;
        bit all_diff;
        if (reset) begin
            shist.delete();
            win.delete();
            m_db = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
        end else begin
            shist.push_back(s);
            if (shist.size() > 3) void'(shist.pop_front());
            v = (shist.size() == 3) ? shist[0] : '0;
            win.push_back(v);
            if (win.size() > D) void'(win.pop_front());
            m_rise = '0; m_fall = '0;
            for (int b = 0; b < W; b++) begin
                all_diff = (win.size() == D);
                foreach (win[k]) if (win[k][b] == m_db[b]) all_diff = 0;
                if (all_diff) begin
                    m_db[b] = ~m_db[b];
                    m_rise[b] = m_db[b];
                    m_fall[b] = ~m_db[b];
                end
            end
            m_any = |(m_rise | m_fall);
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model", {3'b0, s_db, s_rise, s_fall, any_change}, {3'b0, m_db, m_rise, m_fall, m_any});
    endtask

    task automatic hold(input int n, input int b, output int nr, output int nf, output int fd);
        logic db0;
        db0 = s_db[b];
        nr = 0; nf = 0; fd = -1;
        for (int j = 1; j <= n; j++) begin
            tick();
            if (s_rise[b]) nr++;
            if (s_fall[b]) nf++;
            if (fd < 0 && s_db[b] != db0) fd = j;
        end
    endtask

    typedef struct {
        logic r;
        logic [W-1:0] s, db, ri, fa;
        logic an;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input int n, input logic r, input logic [W-1:0] sv, input logic [W-1:0] db,
                       input logic [W-1:0] ri, input logic [W-1:0] fa, input logic an);
        vec_t v;
        v.r = r; v.s = sv; v.db = db; v.ri = ri; v.fa = fa; v.an = an;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        int nr, nf, fd, tr, tf, tfd, hl[W];
        add(5, 1, 4'hF, 4'h0, 4'h0, 4'h0, 0);
        add(9, 0, 4'hF, 4'h0, 4'h0, 4'h0, 0);
        add(1, 0, 4'hF, 4'hF, 4'hF, 4'h0, 1);
        add(2, 0, 4'hF, 4'hF, 4'h0, 4'h0, 0);
        add(9, 0, 4'h0, 4'hF, 4'h0, 4'h0, 0);
        add(1, 0, 4'h0, 4'h0, 4'h0, 4'hF, 1);
        add(2, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(9, 0, 4'hA, 4'h0, 4'h0, 4'h0, 0);
        add(1, 0, 4'hA, 4'hA, 4'hA, 4'h0, 1);
        add(2, 0, 4'hA, 4'hA, 4'h0, 4'h0, 0);

        @(negedge clk);
        foreach (tbl[i]) begin
            reset = tbl[i].r;
            s = tbl[i].s;
            tick();
            chk("vector", {3'b0, s_db, s_rise, s_fall, any_change},
                {3'b0, tbl[i].db, tbl[i].ri, tbl[i].fa, tbl[i].an});
        end

        reset = 1; s = '0;
        tick(); tick();
        reset = 0;
        repeat (3) tick();

        s[0] = 1; hold(20, 0, nr, nf, fd);
        chk("press_latency", 16'(fd), 16'd10);
        chk("press_pulses", {8'(nr), 8'(nf)}, {8'd1, 8'd0});
        s[0] = 0; hold(20, 0, nr, nf, fd);
        chk("release_latency", 16'(fd), 16'd10);
        chk("release_pulses", {8'(nr), 8'(nf)}, {8'd0, 8'd1});

        tr = 0; tf = 0; tfd = -1;
        for (int k = 0; k < 4; k++) begin
            s[1] = ~k[0];
            hold(3, 1, nr, nf, fd);
            tr += nr; tf += nf;
            if (fd >= 0) tfd = fd;
        end
        chk("bounce_quiet", {4'(tr), 4'(tf), 8'(tfd)}, {4'd0, 4'd0, 8'hFF});
        s[1] = 1; hold(20, 1, nr, nf, fd);
        chk("bounce_latency", 16'(fd), 16'd10);
        chk("bounce_rise", 16'(nr), 16'd1);
        s[1] = 0; hold(20, 1, nr, nf, fd);

        s[2] = 1; hold(7, 2, tr, tf, tfd);
        s[2] = 0; hold(20, 2, nr, nf, fd);
        chk("glitch7", {4'(tr + nr), 4'(tf + nf), 8'(fd)}, {4'd0, 4'd0, 8'hFF});
        chk("glitch7_db", 16'(tfd), 16'hFFFF);
        s[2] = 1; hold(8, 2, tr, tf, tfd);
        s[2] = 0; hold(20, 2, nr, nf, fd);
        chk("pulse8_rise", 16'(tr + nr), 16'd1);
        chk("pulse8_edge", 16'(fd), 16'd2);

        s[3] = 1; hold(5, 3, nr, nf, fd);
        reset = 1; tick();
        chk("mid_reset", {3'b0, s_db, s_rise, s_fall, any_change}, 16'h0);
        reset = 0; hold(20, 3, nr, nf, fd);
        chk("mid_reset_latency", 16'(fd), 16'd10);
        chk("mid_reset_pulses", {8'(nr), 8'(nf)}, {8'd1, 8'd0});

        reset = 1; s = '0; tick(); tick();
        reset = 0; repeat (4) tick();
        s[0] = 1;
        repeat (3) tick();
        chk("dc2_wait", {14'b0, s_db2[0], s_rise2[0]}, 16'h0);
        tick();
        chk("dc2_accept", {12'b0, s_db2, s_rise2, any_change2}, {12'b0, 4'h1, 4'h1, 1'b1});

        reset = 1; s = '0; tick();
        reset = 0;
        for (int b = 0; b < W; b++) hl[b] = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < W; b++) begin
                hl[b]--;
                if (hl[b] == 0) begin
                    s[b] = ~s[b];
                    hl[b] = $urandom_range(1, 16);
                end
            end
            reset = ($urandom_range(0, 499) == 0);
            tick();
            checks++;
            if ((s_rise & s_fall) != 0) $display("FAIL exclusive: rise %h fall %h", s_rise, s_fall);
            else passed++;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
